// File: rtl/el_sync_rx.sv
// el_sync_rx
// Clocked receiving end of a 4-phase dual-rail elastic link. Detects the
// data (complete) and null (spacer) phases on the rails, decodes the word to
// single-rail, pushes it into a small FIFO drained by valid/ready, and returns
// the link acknowledge.
//
// Ports
//   clk        clock
//   rst_n      asynchronous active-low reset
//   in         dual-rail data, bit i = in[2i+1:2i] (00 null, 01 zero, 10 one, 11 illegal)
//   ack_o      4-phase link acknowledge
//   out_data   decoded word at FIFO head (holds last value when empty)
//   out_valid  FIFO non-empty
//   out_ready  consumer takes the head when out_valid & out_ready
//   err        sticky flag, illegal rail code seen at a capture
//
// FSM states
//   state     | meaning
//   WAIT_DATA | ack_o low, waiting for synced all_data and a free FIFO slot
//   WAIT_NULL | ack_o high, waiting for synced all_null (spacer)
module el_sync_rx #(
   parameter int WIDTH       = 33,
   parameter int RAIL_NUM    = 2,
   parameter int SYNC_STAGES = 2,
   parameter int DEPTH       = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [RAIL_NUM*WIDTH-1:0] in,
   output logic                      ack_o,
   output logic [WIDTH-1:0]          out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      err
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic {WAIT_DATA, WAIT_NULL} state_t;

   state_t             state;
   logic               all_data;
   logic               all_null;
   logic               any_ill;
   logic [WIDTH-1:0]   dec;
   logic [1:0]         pair;
   logic [SYNC_STAGES-1:0] data_sync;
   logic [SYNC_STAGES-1:0] null_sync;
   logic               data_ok;
   logic               null_ok;

   logic               push_q;
   logic [WIDTH-1:0]   cap_word;
   logic [WIDTH-1:0]   mem [DEPTH];
   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      rd_ptr;
   logic [PW-1:0]      rd_nxt;
   logic [CW-1:0]      count;
   logic [CW-1:0]      cnt_nxt;
   logic               full;
   logic               pop;

   // Completion detect and decode straight off the rails. The rails themselves
   // are not synchronised: the sender keeps them stable until ack_o rises, so
   // sampling them once the synced all_data flag is seen is safe.
   always_comb begin
      all_data = 1'b1;
      all_null = 1'b1;
      any_ill  = 1'b0;
      dec      = '0;
      pair     = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pair = in[2*i +: 2];
         if (pair == 2'b00) all_data = 1'b0;
         else               all_null = 1'b0;
         if (pair == 2'b11) any_ill = 1'b1;
         dec[i] = pair[1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_sync <= '0;
         null_sync <= '0;
      end else begin
         data_sync <= {data_sync[SYNC_STAGES-2:0], all_data};
         null_sync <= {null_sync[SYNC_STAGES-2:0], all_null};
      end
   end

   assign data_ok = data_sync[SYNC_STAGES-1];
   assign null_ok = null_sync[SYNC_STAGES-1];

   // Full uses the registered count only; a pop in the same cycle does not
   // let a capture through until the next edge.
   assign full      = (count == CW'(DEPTH));
   assign out_valid = (count != '0);
   assign pop       = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= WAIT_DATA;
         ack_o    <= 1'b0;
         push_q   <= 1'b0;
         cap_word <= '0;
         err      <= 1'b0;
      end else begin
         push_q <= 1'b0;
         case (state)
            WAIT_DATA: begin
               if (data_ok && !full) begin
                  cap_word <= dec;
                  push_q   <= 1'b1;
                  ack_o    <= 1'b1;
                  if (any_ill) err <= 1'b1;
                  state    <= WAIT_NULL;
               end
            end
            WAIT_NULL: begin
               if (null_ok) begin
                  ack_o <= 1'b0;
                  state <= WAIT_DATA;
               end
            end
            default: begin
               ack_o <= 1'b0;
               state <= WAIT_DATA;
            end
         endcase
      end
   end

   // The capture lands in the FIFO one edge after ack_o rises. A slot is
   // always free by then: count can only fall between the full check and the
   // write, and a new capture needs a full null phase first.
   always_comb begin
      rd_nxt  = pop ? rd_ptr + PW'(1) : rd_ptr;
      cnt_nxt = count + CW'(push_q) - CW'(pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         out_data <= '0;
      end else begin
         if (push_q) begin
            mem[wr_ptr] <= cap_word;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         rd_ptr <= rd_nxt;
         count  <= cnt_nxt;
         // Registered head: the incoming word bypasses the array when it
         // becomes the only entry.
         if (cnt_nxt != '0) begin
            if (push_q && (count == CW'(pop))) out_data <= cap_word;
            else                               out_data <= mem[rd_nxt];
         end
      end
   end

endmodule

// File: tb/tb_el_sync_rx.sv
// tb_el_sync_rx
// Directed bench for el_sync_rx: plain handshake timing, FIFO backpressure
// onto the link, skewed rail arrival, sticky illegal-code flag, async reset
// mid-handshake and a back-to-back stream with ack toggle count.
module tb_el_sync_rx;

   localparam int W = 33;

   logic           clk;
   logic           rst_n;
   logic [2*W-1:0] rails;
   logic           ack_o;
   logic [W-1:0]   out_data;
   logic           out_valid;
   logic           out_ready;
   logic           err;

   int   checks  = 0;
   int   errors  = 0;
   int   toggles = 0;
   logic ack_prev = 1'b0;

   el_sync_rx #(.WIDTH(W), .RAIL_NUM(2), .SYNC_STAGES(2), .DEPTH(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in        (rails),
      .ack_o     (ack_o),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2*W-1:0] enc(input logic [W-1:0] w);
      logic [2*W-1:0] r;
      r = '0;
      for (int i = 0; i < W; i++) r[2*i +: 2] = w[i] ? 2'b10 : 2'b01;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (ack_o !== ack_prev) toggles++;
      ack_prev = ack_o;
   endtask

   task automatic wait_ack(input logic v, input string tag);
      int n;
      n = 0;
      while (ack_o !== v && n < 20) begin
         tick();
         n++;
      end
      chk(tag, 64'(ack_o), 64'(v));
   endtask

   task automatic send_word(input logic [W-1:0] w, input string tag);
      rails = enc(w);
      wait_ack(1'b1, tag);
      rails = '0;
      wait_ack(1'b0, tag);
   endtask

   logic [W-1:0] w3;
   logic [W-1:0] wr;

   initial begin
      rst_n     = 1'b0;
      rails     = '0;
      out_ready = 1'b0;
      #3;
      chk("rst_ack",   64'(ack_o),     64'd0);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_data",  64'(out_data),  64'd0);
      chk("rst_err",   64'(err),       64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // 1: basic handshake latency
      rails = enc(33'h1_0000_0001);
      tick();
      tick();
      chk("t1_ack_early", 64'(ack_o), 64'd0);
      tick();
      chk("t1_ack_rise", 64'(ack_o), 64'd1);
      chk("t1_valid_pre", 64'(out_valid), 64'd0);
      tick();
      chk("t1_valid", 64'(out_valid), 64'd1);
      chk("t1_data",  64'(out_data),  64'h1_0000_0001);
      rails = '0;
      tick();
      tick();
      chk("t1_ack_hold", 64'(ack_o), 64'd1);
      tick();
      chk("t1_ack_fall", 64'(ack_o), 64'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("t1_drained", 64'(out_valid), 64'd0);

      // 2: backpressure with a full FIFO
      send_word(33'h0AA, "t2_w0");
      send_word(33'h155, "t2_w1");
      rails = enc(33'h1FF);
      for (int i = 0; i < 10; i++) tick();
      chk("t2_noack",  64'(ack_o),     64'd0);
      chk("t2_head0",  64'(out_data),  64'h0AA);
      chk("t2_valid",  64'(out_valid), 64'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("t2_head1",  64'(out_data),  64'h155);
      chk("t2_ack_held_off", 64'(ack_o), 64'd0);
      wait_ack(1'b1, "t2_w2_ack");
      rails = '0;
      wait_ack(1'b0, "t2_w2_null");
      chk("t2_head1b", 64'(out_data), 64'h155);
      out_ready = 1'b1;
      tick();
      chk("t2_head2",  64'(out_data), 64'h1FF);
      tick();
      out_ready = 1'b0;
      chk("t2_empty",  64'(out_valid), 64'd0);
      chk("t2_err",    64'(err),       64'd0);

      // 3: skewed rail arrival, one bit per clock
      w3 = 33'h1_2345_6789;
      for (int i = 0; i < W; i++) begin
         rails[2*i +: 2] = w3[i] ? 2'b10 : 2'b01;
         tick();
         chk("t3_noack", 64'(ack_o), 64'd0);
      end
      tick();
      chk("t3_noack_last", 64'(ack_o), 64'd0);
      tick();
      chk("t3_ack", 64'(ack_o), 64'd1);
      tick();
      chk("t3_data", 64'(out_data), 64'(w3));
      rails = '0;
      wait_ack(1'b0, "t3_null");
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("t3_empty", 64'(out_valid), 64'd0);

      // 4: illegal code on bit 5, sticky err
      rails = enc(33'h0);
      rails[11:10] = 2'b11;
      wait_ack(1'b1, "t4_ack");
      chk("t4_err", 64'(err), 64'd1);
      tick();
      chk("t4_data", 64'(out_data), 64'h20);
      rails = '0;
      wait_ack(1'b0, "t4_null");
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      send_word(33'h3, "t4_clean");
      chk("t4_err_sticky", 64'(err), 64'd1);
      chk("t4_clean_data", 64'(out_data), 64'h3);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // 5: reset while ack high and FIFO full
      send_word(33'h11, "t5_w0");
      rails = enc(33'h22);
      wait_ack(1'b1, "t5_w1_ack");
      tick();
      chk("t5_pre_valid", 64'(out_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_rst_ack",   64'(ack_o),     64'd0);
      chk("t5_rst_valid", 64'(out_valid), 64'd0);
      chk("t5_rst_err",   64'(err),       64'd0);
      rails = '0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      send_word(33'h44, "t5_after");
      chk("t5_valid", 64'(out_valid), 64'd1);
      chk("t5_data",  64'(out_data),  64'h44);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("t5_empty", 64'(out_valid), 64'd0);

      // 6: back-to-back stream, consumer always ready
      out_ready = 1'b1;
      ack_prev  = ack_o;
      toggles   = 0;
      for (int k = 0; k < 16; k++) begin
         wr = {1'($urandom_range(1, 0)), 32'($urandom)};
         rails = enc(wr);
         wait_ack(1'b1, "t6_ack");
         tick();
         chk("t6_valid", 64'(out_valid), 64'd1);
         chk("t6_data",  64'(out_data),  64'(wr));
         rails = '0;
         wait_ack(1'b0, "t6_null");
      end
      chk("t6_toggles", 64'(toggles),   64'd32);
      chk("t6_empty",   64'(out_valid), 64'd0);
      out_ready = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
